// File: rtl/div_pkg.sv
// div_pkg: shared types, defaults and helpers for the divider result path.
//   TAMANYO_DEF     default operand/result width
//   PROFUNDIDAD_DEF default result FIFO depth (power of two, >= 2)
//   div_result_t    {coc, res} pair at the default width
//   div_latency()   fixed latency of the pipelined divider, 2*tamanyo+1
package div_pkg;
  localparam int TAMANYO_DEF     = 32;
  localparam int PROFUNDIDAD_DEF = 8;

  typedef struct packed {
    logic [TAMANYO_DEF-1:0] coc;
    logic [TAMANYO_DEF-1:0] res;
  } div_result_t;

  function automatic int div_latency(input int tamanyo);
    return 2 * tamanyo + 1;
  endfunction
endpackage

// File: rtl/div_result_collector_if.sv
// div_result_collector_if: divider-side and consumer-side signals of the
// result collector.
//   Start/Done/Coc/Res  divider issue strobe and result strobe/data
//   Issue_ok            credit back to the issuer
//   Out_*               valid/ready result stream to the consumer
// slave = collector side, master = environment side.
interface div_result_collector_if
  import div_pkg::*;
  #(parameter int tamanyo = TAMANYO_DEF);
  logic               Start;
  logic               Done;
  logic [tamanyo-1:0] Coc;
  logic [tamanyo-1:0] Res;
  logic               Issue_ok;
  logic               Out_valid;
  logic               Out_ready;
  logic [tamanyo-1:0] Out_coc;
  logic [tamanyo-1:0] Out_res;

  modport slave  (input  Start, Done, Coc, Res, Out_ready,
                  output Issue_ok, Out_valid, Out_coc, Out_res);
  modport master (output Start, Done, Coc, Res, Out_ready,
                  input  Issue_ok, Out_valid, Out_coc, Out_res);
endinterface

// File: rtl/div_result_fifo.sv
// div_result_fifo: first-word-fall-through FIFO of {coc, res} pairs.
//   clk, rst_n       clock, async active-low reset
//   push, wr_coc/res write request and data
//   pop              read request (ignored while empty)
//   rd_coc/res       head entry, forced to zero while empty
//   count            occupancy 0..profundidad
//   empty            count == 0
//   push_ok          push accepted this cycle (a full FIFO accepts only
//                    alongside a pop)
module div_result_fifo
  import div_pkg::*;
  #(parameter int tamanyo     = TAMANYO_DEF,
    parameter int profundidad = PROFUNDIDAD_DEF)
  (input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               push,
   input  logic [tamanyo-1:0]                 wr_coc,
   input  logic [tamanyo-1:0]                 wr_res,
   input  logic                               pop,
   output logic [tamanyo-1:0]                 rd_coc,
   output logic [tamanyo-1:0]                 rd_res,
   output logic [$clog2(profundidad+1)-1:0]   count,
   output logic                               empty,
   output logic                               push_ok);

  localparam int CW = $clog2(profundidad + 1);
  localparam int PW = $clog2(profundidad);

  typedef struct packed {
    logic [tamanyo-1:0] coc;
    logic [tamanyo-1:0] res;
  } entry_t;

  entry_t          mem [profundidad];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            full, pop_ok;

  assign full    = (count == CW'(profundidad));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointers are exactly log2(depth) bits, so they wrap on their own;
  // full/empty come from count rather than pointer comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= '{coc: wr_coc, res: wr_res};
  end

  assign rd_coc = empty ? '0 : mem[rd_ptr].coc;
  assign rd_res = empty ? '0 : mem[rd_ptr].res;
endmodule

// File: rtl/div_result_collector.sv
// div_result_collector: buffers divider results and grants issue credit.
//   CLK, RSTa     clock, async active-low reset (shared with the divider)
//   bus           div_result_collector_if.slave (Start/Done/Coc/Res in,
//                 Issue_ok out, Out_valid/Out_ready/Out_coc/Out_res stream)
//   Count         FIFO occupancy
//   Overflow     sticky: a result arrived with the FIFO full and no pop
//   Protocol_err sticky: Start without credit, or Done with nothing in flight
module div_result_collector
  import div_pkg::*;
  #(parameter int tamanyo     = TAMANYO_DEF,
    parameter int profundidad = PROFUNDIDAD_DEF)
  (input  logic                              CLK,
   input  logic                              RSTa,
   div_result_collector_if.slave             bus,
   output logic [$clog2(profundidad+1)-1:0]  Count,
   output logic                              Overflow,
   output logic                              Protocol_err);

  localparam int CW = $clog2(profundidad + 1);

  logic [CW-1:0] in_flight;
  logic [CW:0]   committed;
  logic          empty, push_ok, pop;
  logic          start_nocredit, done_orphan;

  // Every slot is either occupied or promised to an in-flight division;
  // credit is granted only while at least one slot remains uncommitted.
  assign committed    = {1'b0, Count} + {1'b0, in_flight};
  assign bus.Issue_ok = (committed < (CW+1)'(profundidad));

  assign bus.Out_valid = !empty;
  assign pop           = bus.Out_valid && bus.Out_ready;

  assign start_nocredit = bus.Start && !bus.Issue_ok;
  assign done_orphan    = bus.Done && (in_flight == '0);

  div_result_fifo #(.tamanyo(tamanyo), .profundidad(profundidad)) u_fifo (
    .clk     (CLK),
    .rst_n   (RSTa),
    .push    (bus.Done),
    .wr_coc  (bus.Coc),
    .wr_res  (bus.Res),
    .pop     (pop),
    .rd_coc  (bus.Out_coc),
    .rd_res  (bus.Out_res),
    .count   (Count),
    .empty   (empty),
    .push_ok (push_ok)
  );

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      in_flight    <= '0;
      Overflow     <= 1'b0;
      Protocol_err <= 1'b0;
    end else begin
      // Saturate at both ends so a misbehaving issuer cannot wrap the count.
      case ({bus.Start, bus.Done})
        2'b10: if (in_flight != CW'(profundidad)) in_flight <= in_flight + 1'b1;
        2'b01: if (in_flight != '0)               in_flight <= in_flight - 1'b1;
        default: ;
      endcase
      if (bus.Done && !push_ok)          Overflow     <= 1'b1;
      if (start_nocredit || done_orphan) Protocol_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_div_result_collector.sv
module tb_div_result_collector;
  import div_pkg::*;

  localparam int T   = 32;
  localparam int P   = 4;
  localparam int CW  = $clog2(P + 1);
  localparam int LAT = div_latency(T);

  logic CLK  = 1'b0;
  logic RSTa = 1'b1;
  always #5 CLK = ~CLK;

  div_result_collector_if #(.tamanyo(T)) bus();
  logic [CW-1:0] Count;
  logic          Overflow, Protocol_err;

  div_result_collector #(.tamanyo(T), .profundidad(P)) dut (
    .CLK          (CLK),
    .RSTa         (RSTa),
    .bus          (bus),
    .Count        (Count),
    .Overflow     (Overflow),
    .Protocol_err (Protocol_err)
  );

  // Behavioural stand-in for the pipelined divider: fixed latency, shares RSTa.
  logic [T-1:0]   num = '0, den = 32'd1;
  logic           force_done = 1'b0;
  logic [T-1:0]   force_coc = '0, force_res = '0;
  logic [LAT-1:0] pv;
  logic [T-1:0]   pq [LAT];
  logic [T-1:0]   pr [LAT];

  always @(posedge CLK or negedge RSTa) begin
    if (!RSTa) pv <= '0;
    else begin
      pv    <= {pv[LAT-2:0], bus.Start};
      pq[0] <= bus.Start ? T'($signed(num) / $signed(den)) : '0;
      pr[0] <= bus.Start ? T'($signed(num) % $signed(den)) : '0;
      for (int i = 1; i < LAT; i++) begin
        pq[i] <= pq[i-1];
        pr[i] <= pr[i-1];
      end
    end
  end

  assign bus.Done = pv[LAT-1] | force_done;
  assign bus.Coc  = force_done ? force_coc : pq[LAT-1];
  assign bus.Res  = force_done ? force_res : pr[LAT-1];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [T-1:0] n, input logic [T-1:0] d);
    bus.Start = 1'b1; num = n; den = d;
    @(negedge CLK);
    bus.Start = 1'b0;
  endtask

  task automatic wait_count(input int target, input string name);
    int k = 0;
    while (int'(Count) != target && k < 200) begin @(negedge CLK); k++; end
    check(name, Count, target);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!bus.Out_valid && k < 200) begin @(negedge CLK); k++; end
    check(name, bus.Out_valid, 1);
  endtask

  task automatic do_reset();
    RSTa = 1'b0; force_done = 1'b0; bus.Start = 1'b0; bus.Out_ready = 1'b0;
    @(negedge CLK);
    RSTa = 1'b1;
    @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " Issue_ok"},     bus.Issue_ok,  1);
    check({tag, " Out_valid"},    bus.Out_valid, 0);
    check({tag, " Out_coc"},      bus.Out_coc,   0);
    check({tag, " Out_res"},      bus.Out_res,   0);
    check({tag, " Count"},        Count,         0);
    check({tag, " Overflow"},     Overflow,      0);
    check({tag, " Protocol_err"}, Protocol_err,  0);
  endtask

  typedef struct {
    logic [31:0] num, den, coc, res;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2};
    tbl[1] = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE};
    tbl[2] = '{32'd7,          32'd100,        32'd0,          32'd7};
    tbl[3] = '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
    tbl[4] = '{32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2};
    tbl[5] = '{32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   32'd0};

    bus.Start = 1'b0; bus.Out_ready = 1'b0;
    #2 RSTa = 1'b0;
    #2 check_reset_outputs("reset");
    @(negedge CLK); RSTa = 1'b1; @(negedge CLK);

    // Single divisions through the whole path, consumer always ready.
    bus.Out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].num, tbl[i].den);
      wait_valid($sformatf("vec%0d valid", i));
      check($sformatf("vec%0d coc", i), bus.Out_coc, tbl[i].coc);
      check($sformatf("vec%0d res", i), bus.Out_res, tbl[i].res);
      @(negedge CLK);
      check($sformatf("vec%0d drained", i), Count, 0);
    end
    check("single prot_err", Protocol_err, 0);

    // Credit exhaustion with a stalled consumer, then ordered drain.
    bus.Out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("credit before start%0d", i), bus.Issue_ok, 1);
      issue(tbl[i].num, tbl[i].den);
    end
    check("credit after 4 starts", bus.Issue_ok, 0);
    wait_count(4, "fill count");
    check("credit when full", bus.Issue_ok, 0);
    check("fill overflow", Overflow, 0);
    bus.Out_ready = 1'b1;
    check("first head coc", bus.Out_coc, tbl[0].coc);
    @(negedge CLK);
    bus.Out_ready = 1'b0;
    check("credit after pop", bus.Issue_ok, 1);
    check("count after pop", Count, 3);
    bus.Out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      check($sformatf("order%0d coc", i), bus.Out_coc, tbl[i].coc);
      check($sformatf("order%0d res", i), bus.Out_res, tbl[i].res);
      @(negedge CLK);
    end
    check("order drained", Count, 0);

    // Full FIFO, pop and Done in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) issue(tbl[i].num, tbl[i].den);
    wait_count(4, "refill count");
    bus.Out_ready = 1'b1;
    force_done = 1'b1; force_coc = 32'hA5A50001; force_res = 32'h5A5A0002;
    @(negedge CLK);
    force_done = 1'b0;
    check("full push+pop count", Count, 4);
    check("full push+pop overflow", Overflow, 0);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("pp order%0d coc", i), bus.Out_coc, tbl[i].coc);
      @(negedge CLK);
    end
    check("tail coc", bus.Out_coc, 32'hA5A50001);
    check("tail res", bus.Out_res, 32'h5A5A0002);
    @(negedge CLK);
    check("tail drained", Count, 0);
    check("orphan done prot_err", Protocol_err, 1);

    // Full FIFO, stalled consumer: the forced result must be dropped.
    do_reset();
    for (int i = 0; i < 4; i++) issue(tbl[i].num, tbl[i].den);
    wait_count(4, "ovf fill count");
    check("ovf pre prot_err", Protocol_err, 0);
    force_done = 1'b1; force_coc = 32'hDEADBEEF; force_res = 32'h0BADF00D;
    @(negedge CLK);
    force_done = 1'b0;
    check("ovf flag", Overflow, 1);
    check("ovf count", Count, 4);
    check("ovf prot_err", Protocol_err, 1);
    bus.Out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf keep%0d coc", i), bus.Out_coc, tbl[i].coc);
      @(negedge CLK);
    end
    check("ovf drained", Count, 0);
    check("ovf sticky", Overflow, 1);

    // Empty FIFO with Done and a ready consumer: no same-cycle bypass.
    do_reset();
    bus.Out_ready = 1'b1;
    force_done = 1'b1; force_coc = 32'h00001234; force_res = 32'h00005678;
    #1 check("no bypass", bus.Out_valid, 0);
    @(negedge CLK);
    force_done = 1'b0;
    check("empty push valid", bus.Out_valid, 1);
    check("empty push coc", bus.Out_coc, 32'h00001234);
    check("empty push res", bus.Out_res, 32'h00005678);
    check("empty push prot_err", Protocol_err, 1);
    check("empty push overflow", Overflow, 0);
    @(negedge CLK);
    check("empty push drained", Count, 0);

    // Reset with entries queued and divisions in flight.
    do_reset();
    for (int i = 0; i < 3; i++) issue(tbl[i].num, tbl[i].den);
    repeat (7) @(negedge CLK);
    issue(tbl[3].num, tbl[3].den);
    issue(tbl[4].num, tbl[4].den);
    wait_count(3, "pre-reset count");
    check("pre-reset prot_err", Protocol_err, 1);
    RSTa = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge CLK);
    RSTa = 1'b1;
    repeat (80) @(negedge CLK);
    check("post-reset Issue_ok", bus.Issue_ok, 1);
    check("post-reset Count", Count, 0);
    check("post-reset Out_valid", bus.Out_valid, 0);
    check("post-reset prot_err", Protocol_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
